// File: rtl/segment_to_binary_if.sv
// Handshake bundle for segment_to_binary: pattern input side and decoded result side.
// The requester uses master, the decoder uses slave.
interface segment_to_binary_if #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) ();
    logic [7*DIGITS-1:0] seg_in;
    logic                in_valid;
    logic                in_ready;
    logic [BIN_W-1:0]    bin_out;
    logic [4*DIGITS-1:0] bcd_out;
    logic                err;
    logic                ovf;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output seg_in, in_valid, out_ready,
        input  in_ready, bin_out, bcd_out, err, ovf, out_valid
    );

    modport slave (
        input  seg_in, in_valid, out_ready,
        output in_ready, bin_out, bcd_out, err, ovf, out_valid
    );
endinterface

// File: rtl/segment_to_binary.sv
// Recovers BCD digits and a saturating binary value from active-low 7-segment patterns,
// one digit per clock MSD first; result DIGITS cycles after accept, held until out_ready.
module segment_to_binary #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    segment_to_binary_if.slave   bus
);
    localparam int SEG_W = 7 * DIGITS;
    localparam int BCD_W = 4 * DIGITS;
    localparam int ACC_W = BIN_W + 4;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [ACC_W-1:0] MAX_VAL = {4'b0000, {BIN_W{1'b1}}};
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, DECODE, DONE} state_t;

    state_t             r_state;
    logic [SEG_W-1:0]   r_seg;
    logic [IDX_W-1:0]   r_idx;
    logic [BIN_W-1:0]   r_acc;
    logic [BCD_W-1:0]   r_bcd_work;
    logic               r_err_work;
    logic               r_ovf_work;
    logic [BIN_W-1:0]   r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_err;
    logic               r_ovf;
    logic               r_out_valid;

    logic [6:0]         w_pat;
    logic               w_legal;
    logic [3:0]         w_dig;
    logic [3:0]         w_digit;
    logic [3:0]         w_nib;
    logic [ACC_W-1:0]   w_sum;
    logic               w_ovf_next;
    logic               w_err_next;
    logic [BIN_W-1:0]   w_acc_next;
    logic [BCD_W-1:0]   w_bcd_next;

    // p[0] is segment a; the case labels read in abcdefg order.
    function automatic logic [4:0] decode_seg(input logic [6:0] p);
        logic [4:0] r;
        case ({p[0], p[1], p[2], p[3], p[4], p[5], p[6]})
            7'b0000001: r = {1'b1, 4'd0};
            7'b1001111: r = {1'b1, 4'd1};
            7'b0010010: r = {1'b1, 4'd2};
            7'b0000110: r = {1'b1, 4'd3};
            7'b1001100: r = {1'b1, 4'd4};
            7'b0100100: r = {1'b1, 4'd5};
            7'b0100000: r = {1'b1, 4'd6};
            7'b0001111: r = {1'b1, 4'd7};
            7'b0000000: r = {1'b1, 4'd8};
            7'b0000100: r = {1'b1, 4'd9};
            default:    r = {1'b0, 4'd0};
        endcase
        return r;
    endfunction

    always_comb begin
        w_pat      = r_seg[7*r_idx +: 7];
        {w_legal, w_dig} = decode_seg(w_pat);
        w_digit    = w_legal ? w_dig : 4'd0;
        w_nib      = w_legal ? w_dig : 4'hF;
        w_sum      = ({4'b0000, r_acc} << 3) + ({4'b0000, r_acc} << 1)
                   + {{(ACC_W-4){1'b0}}, w_digit};
        // Saturation is sticky so later digits cannot wrap back into range.
        w_ovf_next = r_ovf_work | (w_sum > MAX_VAL);
        w_acc_next = w_ovf_next ? {BIN_W{1'b1}} : w_sum[BIN_W-1:0];
        w_err_next = r_err_work | ~w_legal;
        w_bcd_next = r_bcd_work;
        w_bcd_next[4*r_idx +: 4] = w_nib;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_seg       <= '0;
            r_idx       <= '0;
            r_acc       <= '0;
            r_bcd_work  <= '0;
            r_err_work  <= 1'b0;
            r_ovf_work  <= 1'b0;
            r_bin       <= '0;
            r_bcd       <= '0;
            r_err       <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_seg      <= bus.seg_in;
                        r_idx      <= IDX_LAST;
                        r_acc      <= '0;
                        r_bcd_work <= '0;
                        r_err_work <= 1'b0;
                        r_ovf_work <= 1'b0;
                        r_state    <= DECODE;
                    end
                end
                DECODE: begin
                    r_acc      <= w_acc_next;
                    r_bcd_work <= w_bcd_next;
                    r_err_work <= w_err_next;
                    r_ovf_work <= w_ovf_next;
                    r_idx      <= r_idx - 1'b1;
                    if (r_idx == '0) begin
                        // An illegal digit makes the binary value meaningless.
                        r_bin       <= w_err_next ? '0 : w_acc_next;
                        r_ovf       <= w_ovf_next & ~w_err_next;
                        r_err       <= w_err_next;
                        r_bcd       <= w_bcd_next;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE) & ~rst;
    assign bus.bin_out   = r_bin;
    assign bus.bcd_out   = r_bcd;
    assign bus.err       = r_err;
    assign bus.ovf       = r_ovf;
    assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_segment_to_binary.sv
// Directed bench for segment_to_binary: a 7-bit and a 6-bit instance run in lockstep
// on the same stimulus; the 6-bit one exercises saturation.
module tb_segment_to_binary;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   lat;

    always #5 clk = ~clk;

    segment_to_binary_if #(.DIGITS(2), .BIN_W(7)) bus7 ();
    segment_to_binary_if #(.DIGITS(2), .BIN_W(6)) bus6 ();

    assign bus6.seg_in    = bus7.seg_in;
    assign bus6.in_valid  = bus7.in_valid;
    assign bus6.out_ready = bus7.out_ready;

    segment_to_binary #(.DIGITS(2), .BIN_W(7)) dut  (.clk(clk), .rst(rst), .bus(bus7));
    segment_to_binary #(.DIGITS(2), .BIN_W(6)) dut6 (.clk(clk), .rst(rst), .bus(bus6));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
            $error("check %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Segment field for a digit, bit 0 = segment a; table written in abcdefg order.
    function automatic logic [6:0] enc(input int d);
        logic [6:0] s;
        case (d)
            0: s = 7'b0000001;
            1: s = 7'b1001111;
            2: s = 7'b0010010;
            3: s = 7'b0000110;
            4: s = 7'b1001100;
            5: s = 7'b0100100;
            6: s = 7'b0100000;
            7: s = 7'b0001111;
            8: s = 7'b0000000;
            default: s = 7'b0000100;
        endcase
        return {s[0], s[1], s[2], s[3], s[4], s[5], s[6]};
    endfunction

    function automatic logic [13:0] pack2(input int tens, input int units);
        return {enc(tens), enc(units)};
    endfunction

    // Returns #1 after the acceptance edge with in_valid dropped.
    task automatic send(input logic [13:0] s);
        int ok;
        ok = 0;
        bus7.seg_in   = s;
        bus7.in_valid = 1'b1;
        for (int k = 0; k < 20 && ok == 0; k++) begin
            if (bus7.in_ready) ok = 1;
            @(posedge clk); #1;
        end
        bus7.in_valid = 1'b0;
        chk("accept", ok, 1);
    endtask

    task automatic wait_out(output int l);
        int found;
        found = 0;
        l = 0;
        for (int k = 1; k <= 20 && found == 0; k++) begin
            @(posedge clk); #1;
            if (bus7.out_valid) begin
                found = 1;
                l = k;
            end
        end
    endtask

    task automatic consume();
        bus7.out_ready = 1'b1;
        @(posedge clk); #1;
        bus7.out_ready = 1'b0;
        chk("consume_ovalid", bus7.out_valid, 0);
    endtask

    initial begin
        int seen;
        int tens;
        int units;
        bus7.seg_in    = '0;
        bus7.in_valid  = 1'b0;
        bus7.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus7.in_ready, 0);
        chk("rst_out_valid", bus7.out_valid, 0);
        chk("rst_bin", bus7.bin_out, 0);
        chk("rst_bcd", bus7.bcd_out, 0);
        chk("rst_err", bus7.err, 0);
        chk("rst_ovf", bus7.ovf, 0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", bus7.in_ready, 1);

        // 19 written out by hand: tens=1 (1111001), units=9 (0010000), bit 0 = a
        send(14'b1111001_0010000);
        wait_out(lat);
        chk("t1_latency", lat, 2);
        chk("t1_bcd", bus7.bcd_out, 32'h19);
        chk("t1_bin", bus7.bin_out, 19);
        chk("t1_err", bus7.err, 0);
        chk("t1_ovf", bus7.ovf, 0);
        consume();

        for (int v = 0; v < 16; v++) begin
            tens  = v / 10;
            units = v % 10;
            send(pack2(tens, units));
            wait_out(lat);
            chk($sformatf("sweep_bin_%0d", v), bus7.bin_out, v);
            chk($sformatf("sweep_bcd_%0d", v), bus7.bcd_out, (tens << 4) | units);
            consume();
        end

        send({enc(4), 7'b1111111});
        wait_out(lat);
        chk("blank_err", bus7.err, 1);
        chk("blank_bin", bus7.bin_out, 0);
        chk("blank_ovf", bus7.ovf, 0);
        chk("blank_units", bus7.bcd_out[3:0], 4'hF);
        chk("blank_tens", bus7.bcd_out[7:4], 4'h4);
        consume();

        send(pack2(4, 2));
        wait_out(lat);
        bus7.seg_in   = pack2(5, 7);
        bus7.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("stall_ovalid", bus7.out_valid, 1);
            chk("stall_in_ready", bus7.in_ready, 0);
            chk("stall_bin", bus7.bin_out, 42);
        end
        bus7.out_ready = 1'b1;
        @(posedge clk); #1;
        bus7.out_ready = 1'b0;
        chk("hs_ovalid", bus7.out_valid, 0);
        chk("hs_in_ready", bus7.in_ready, 1);
        chk("hs_bin_hold", bus7.bin_out, 42);
        @(posedge clk); #1;
        bus7.in_valid = 1'b0;
        chk("second_accepted", bus7.in_ready, 0);
        wait_out(lat);
        chk("second_latency", lat, 2);
        chk("second_bin", bus7.bin_out, 57);
        consume();

        send(pack2(8, 8));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_in_ready", bus7.in_ready, 0);
        chk("midrst_ovalid", bus7.out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_release_ready", bus7.in_ready, 1);
        chk("midrst_bin_cleared", bus7.bin_out, 0);
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus7.out_valid) seen = 1;
        end
        chk("midrst_no_output", seen, 0);

        send(pack2(9, 9));
        wait_out(lat);
        chk("w6_99_bin", bus6.bin_out, 63);
        chk("w6_99_ovf", bus6.ovf, 1);
        chk("w6_99_err", bus6.err, 0);
        chk("w6_99_bcd", bus6.bcd_out, 32'h99);
        chk("w7_99_bin", bus7.bin_out, 99);
        chk("w7_99_ovf", bus7.ovf, 0);
        consume();

        send(pack2(6, 3));
        wait_out(lat);
        chk("w6_63_bin", bus6.bin_out, 63);
        chk("w6_63_ovf", bus6.ovf, 0);
        consume();

        send(pack2(6, 4));
        wait_out(lat);
        chk("w6_64_bin", bus6.bin_out, 63);
        chk("w6_64_ovf", bus6.ovf, 1);
        consume();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete, observed timeout, expected finish");
        $fatal(1, "bench timeout");
    end
endmodule
